// File: rtl/nanov_alu_seq_if.sv
// Request/response handshake bundle between a client and the nanoV ALU sequencer.
interface nanov_alu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/nanov_alu_seq.sv
// Operand/result sequencer for the nanoV bit-serial ALU: streams operands LSB-first,
// carries between bits, and assembles a parallel result.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for a request, in_ready high
// ST_RUN  | one operand bit per clock into the serial ALU
// ST_DONE | result held on out_result until out_ready
module nanov_alu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rstn,
  nanov_alu_seq_if.slave     bus,
  output logic [3:0]         alu_op,
  output logic               alu_a,
  output logic               alu_b,
  output logic               alu_cy_in,
  input  logic               alu_d,
  input  logic               alu_cy_out,
  input  logic               alu_lts
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(XLEN - 1);

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [3:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cy_q, cy_d;

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    cy_d        = cy_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d    = ST_RUN;
          in_ready_d = 1'b0;
          op_d       = bus.in_op;
          a_d        = bus.in_a;
          b_d        = bus.in_b;
          cnt_d      = '0;
          // Subtract-type ops (SUB/SLT/SLTU) form a + ~b + 1, so seed carry with 1.
          cy_d       = bus.in_op[1] | bus.in_op[3];
        end
      end
      ST_RUN: begin
        cy_d  = alu_cy_out;
        res_d = {alu_d, res_q[XLEN-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          // Compares are decided on the sign bit: signed from the ALU, unsigned from borrow.
          if (op_q[2:0] == 3'b010) begin
            res_d = {{(XLEN-1){1'b0}}, alu_lts};
          end else if (op_q[2:0] == 3'b011) begin
            res_d = {{(XLEN-1){1'b0}}, ~alu_cy_out};
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      cy_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      cy_q        <= cy_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = res_q;

  assign alu_op    = op_q;
  assign alu_a     = (state_q == ST_RUN) & a_q[0];
  assign alu_b     = (state_q == ST_RUN) & b_q[0];
  assign alu_cy_in = (state_q == ST_RUN) & cy_q;

endmodule

// File: tb/tb_nanov_alu_seq.sv
// Bench for nanov_alu_seq: behavioural serial ALU, word-level reference model and a
// per-cycle compare process, plus directed literal cases and randomized traffic.
module tb_nanov_alu_seq;
  localparam int XLEN = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  nanov_alu_seq_if #(.XLEN(XLEN)) bus ();

  logic [3:0] alu_op;
  logic       alu_a, alu_b, alu_cy_in;
  logic       alu_d, alu_cy_out, alu_lts;

  nanov_alu_seq #(.XLEN(XLEN), .CNT_W(5)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus.slave),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cy_in  (alu_cy_in),
    .alu_d      (alu_d),
    .alu_cy_out (alu_cy_out),
    .alu_lts    (alu_lts)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural single-bit ALU standing in for the real serial ALU.
  logic s_arith, s_bb, s_sum;
  always_comb begin
    s_arith    = (alu_op == 4'b0000) || (alu_op == 4'b1000) ||
                 (alu_op == 4'b0010) || (alu_op == 4'b0011);
    s_bb       = alu_b ^ (alu_op[3] | alu_op[1]);
    s_sum      = alu_a ^ s_bb ^ alu_cy_in;
    alu_d      = 1'b0;
    alu_cy_out = 1'b0;
    alu_lts    = (alu_a != alu_b) ? alu_a : s_sum;
    if (s_arith) begin
      alu_d      = s_sum;
      alu_cy_out = (alu_a & s_bb) | (alu_a & alu_cy_in) | (s_bb & alu_cy_in);
    end else if (alu_op == 4'b0100) alu_d = alu_a ^ alu_b;
    else if (alu_op == 4'b0110) alu_d = alu_a | alu_b;
    else if (alu_op == 4'b0111) alu_d = alu_a & alu_b;
  end

  function automatic logic [31:0] ref_result(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_cy(logic [3:0] op, logic [31:0] a, logic [31:0] b, int i);
    logic        c0;
    logic [63:0] bb, mask, s;
    c0 = op[1] | op[3];
    if (i == 0) return c0;
    if (!(op == 4'b0000 || op == 4'b1000 || op == 4'b0010 || op == 4'b0011)) return 1'b0;
    bb   = c0 ? {32'b0, ~b} : {32'b0, b};
    mask = (64'd1 << i) - 64'd1;
    s    = ({32'b0, a} & mask) + (bb & mask) + {63'b0, c0};
    return s[i];
  endfunction

  // Reference model: phase 0 idle, 1 streaming bit m_bit, 2 result waiting.
  int          m_phase   = 0;
  int          m_bit     = 0;
  int          m_acc_cnt = 0;
  logic [3:0]  m_op      = '0;
  logic [31:0] m_a = '0, m_b = '0, m_exp = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_phase <= 0;
      m_bit   <= 0;
    end else begin
      case (m_phase)
        0: if (bus.in_valid) begin
          m_phase   <= 1;
          m_bit     <= 0;
          m_op      <= bus.in_op;
          m_a       <= bus.in_a;
          m_b       <= bus.in_b;
          m_exp     <= ref_result(bus.in_op, bus.in_a, bus.in_b);
          m_acc_cnt <= m_acc_cnt + 1;
        end
        1: if (m_bit == XLEN - 1) m_phase <= 2;
           else m_bit <= m_bit + 1;
        default: if (bus.out_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("in_ready", bus.in_ready, m_phase == 0);
      chk("out_valid", bus.out_valid, m_phase == 2);
      if (m_phase == 2) chk("out_result", bus.out_result, m_exp);
      if (m_phase == 1) begin
        chk("alu_op", alu_op, m_op);
        chk("alu_a", alu_a, m_a[m_bit]);
        chk("alu_b", alu_b, m_b[m_bit]);
        chk("alu_cy_in", alu_cy_in, exp_cy(m_op, m_a, m_b, m_bit));
      end else begin
        chk("alu_idle_bits", {alu_a, alu_b, alu_cy_in}, 3'b000);
      end
    end
  end

  logic rdy_rand = 1'b0, rdy_force = 1'b0, rdy_rnd = 1'b0;
  always @(negedge clk) rdy_rnd <= ($urandom_range(0, 3) != 0);
  always_comb bus.out_ready = rdy_rand ? rdy_rnd : rdy_force;

  logic [3:0] op_tab [14] = '{4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111,
                              4'b0001, 4'b0101, 4'b1001, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic send(logic [3:0] op, logic [31:0] a, logic [31:0] b, bit jitter);
    int start;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    start        = m_acc_cnt;
    for (int k = 0; k < 200 && m_acc_cnt == start; k++) begin
      @(posedge clk);
      #1;
      if (jitter && m_acc_cnt == start) begin
        bus.in_op = op_tab[$urandom_range(0, 13)];
        bus.in_a  = rand_operand();
        bus.in_b  = ($urandom_range(0, 4) == 0) ? bus.in_a : rand_operand();
      end
    end
    chk("accept_timeout", m_acc_cnt != start, 1);
    bus.in_valid = 1'b0;
    bus.in_op    = 4'($urandom);
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 100 && m_phase != 2; k++) @(negedge clk);
    chk("done_timeout", m_phase == 2, 1);
  endtask

  task automatic release_result();
    rdy_force = 1'b1;
    @(posedge clk);
    #1 rdy_force = 1'b0;
  endtask

  task automatic finish_dir(string name, logic [31:0] lit);
    wait_done();
    chk(name, bus.out_result, lit);
    chk({"model_", name}, m_exp, lit);
    release_result();
  endtask

  task automatic dir(string name, logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] lit);
    send(op, a, b, 1'b0);
    finish_dir(name, lit);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    #2 rstn = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_alu", {alu_op, alu_a, alu_b, alu_cy_in}, 7'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    send(4'b0000, 32'h7FFF_FFFF, 32'h1, 1'b0);
    repeat (31) @(posedge clk);
    #1 chk("latency_31", bus.out_valid, 0);
    @(posedge clk);
    #1 chk("latency_32", bus.out_valid, 1);
    finish_dir("add_ovf", 32'h8000_0000);

    send(4'b1000, 32'h0, 32'h1, 1'b0);
    chk("sub_bit0_cy", alu_cy_in, 1);
    finish_dir("sub_0_1", 32'hFFFF_FFFF);

    dir("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0);
    dir("slt_neg",  4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h1);
    dir("sltu_big", 4'b0011, 32'hFFFF_FFFF, 32'h1, 32'h0);
    dir("sltu_1_2", 4'b0011, 32'h1, 32'h2, 32'h1);
    dir("slt_eq",   4'b0010, 32'h5, 32'h5, 32'h0);
    dir("and",      4'b0111, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'h00F0_A5A5);
    dir("or",       4'b0110, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'hFFF0_FFFF);
    dir("xor",      4'b0100, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'hFF00_5A5A);
    dir("undef_op", 4'b0101, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0);

    send(4'b0000, 32'h1234, 32'h1, 1'b0);
    wait_done();
    bus.in_valid = 1'b1;
    bus.in_op    = 4'b1000;
    bus.in_a     = 32'd9;
    bus.in_b     = 32'd4;
    repeat (10) @(negedge clk);
    chk("hold_in_ready", bus.in_ready, 0);
    chk("hold_result", bus.out_result, 32'h1235);
    rdy_force = 1'b1;
    @(posedge clk);
    #1 rdy_force = 1'b0;
    chk("bubble_in_ready", bus.in_ready, 1);
    chk("bubble_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1 chk("accept_after_bubble", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    finish_dir("sub_9_4", 32'd5);

    send(4'b0000, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
    for (int k = 0; k < 100 && !(m_phase == 1 && m_bit == 17); k++) @(negedge clk);
    chk("reach_bit17", m_bit, 17);
    #2 rstn = 1'b0;
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_result", bus.out_result, 0);
    chk("abort_alu", {alu_a, alu_b, alu_cy_in}, 3'b000);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    dir("post_rst_add", 4'b0000, 32'd3, 32'd4, 32'd7);

    rdy_rand = 1'b1;
    for (int t = 0; t < 60; t++) begin
      logic [31:0] ra, rb;
      ra = rand_operand();
      rb = ($urandom_range(0, 4) == 0) ? ra : rand_operand();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(op_tab[$urandom_range(0, 13)], ra, rb, 1'b1);
    end
    for (int k = 0; k < 300 && m_phase != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("drain_in_ready", bus.in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
